trigger_burst_gen: RTL
======================

# trigger_burst_gen

Downstream consumer of the countdown trigger. It watches the level `trigger` produced by the countdown state machine. On each rising edge it emits a burst of `PULSE_COUNT` pulses, each `HIGH_CYCLES` wide and separated by `LOW_CYCLES` gaps. It then holds `done` until `trigger` falls, which re-arms it for the next edge. All outputs are Moore outputs, decoded from registered state only.

## Interface
- `PULSE_COUNT`, default 3: pulses per burst; must be ≥1.
- `HIGH_CYCLES`, default 2: clock cycles `pulse` stays high per pulse; must be ≥1.
- `LOW_CYCLES`, default 3: clock cycles `pulse` stays low between pulses; must be ≥1.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset; one clock domain, async active-high reset.
- `trigger` input, 1 bit: level from the upstream countdown, synchronous to `clk`.
- `pulse` output, 1 bit: burst output.
- `busy` output, 1 bit: high while a burst is in progress.
- `done` output, 1 bit: high after a burst completes, until re-armed.

## Operation
- Edge detect: register `trig_q` takes `trigger` every cycle; reset value 0; `rise = trigger & ~trig_q`.
- Because `trig_q` resets to 0, a `trigger` already high at the first edge after reset counts as a rise.
- Registers:
  - state, with states IDLE, HIGH, LOW, DONE;
  - phase counter `cnt`, width `$clog2(max(HIGH_CYCLES, LOW_CYCLES)+1)`;
  - pulse counter `npulse`, width `$clog2(PULSE_COUNT+1)`.
- Transitions (`cnt` clears to 0 on every state change):
  - IDLE: if `rise` → HIGH, `npulse`=0; else stay.
  - HIGH: `cnt`++. When `cnt==HIGH_CYCLES-1`:
    - if `npulse==PULSE_COUNT-1` → DONE;
    - else → LOW.
  - LOW: `cnt`++. When `cnt==LOW_CYCLES-1` → HIGH and `npulse`++.
  - DONE: if `trigger==0` → IDLE; else stay.
- Output decode:
  - `pulse` = (state==HIGH);
  - `busy` = (state==HIGH or LOW);
  - `done` = (state==DONE).
- Rises during HIGH, LOW or DONE are ignored; they are never queued.
- A `trigger` fall mid-burst does not abort the burst.
  - If `trigger` is already low when DONE is entered, DONE lasts exactly one cycle, then → IDLE.
- Counter compares are done at full counter width; there is no wrap-around in legal operation.

## Timing
- Reset:
  - `rst` high forces, asynchronously, state=IDLE, `cnt`=0, `npulse`=0, `trig_q`=0.
  - Outputs go `pulse`=0, `busy`=0, `done`=0 without waiting for a clock edge.
  - Reset mid-burst truncates the current pulse immediately.
- Start latency:
  - `trigger` is sampled high with `trig_q`=0 at edge k, and state becomes HIGH at edge k.
  - `pulse` is high for the cycle following edge k, so `pulse` lags the `trigger` transition by one clock edge.
- Burst length: `busy` is high for exactly PULSE_COUNT·HIGH_CYCLES + (PULSE_COUNT−1)·LOW_CYCLES cycles; with defaults this is 12.
- `done` rises on the same edge that `busy` falls.
- Re-arm:
  - The first edge sampling `trigger`=0 in DONE returns the block to IDLE.
  - A new burst needs `trigger` low for ≥1 sampled cycle, then high.
- With the upstream countdown (trigger high 4 edges after its reset), the first `pulse` is high 5 edges after reset release.

## Test plan
- **Reset values:** assert `rst` with `trigger`=1 → `pulse`/`busy`/`done` = 0 throughout. Release reset → HIGH after the first edge.
- **Default burst:** rise `trigger` and hold it high → `pulse` sequence 1,1,0,0,0,1,1,0,0,0,1,1; `busy`=1 for 12 cycles; then `done`=1 and stays 1 while `trigger` stays high.
- **Re-arm:** drop `trigger` in DONE → IDLE one edge later with `done`=0. Raise `trigger` again → an identical 12-cycle burst.
- **Ignored edges:** toggle `trigger` 0/1 repeatedly during a burst → burst pattern unchanged. `done` is held exactly 1 cycle if `trigger` is low at burst end, and no second burst starts.
- **Async reset mid-burst:** assert `rst` between edges during the 2nd pulse → `pulse`/`busy` drop to 0 before the next edge. After release with `trigger`=1 → a fresh full 3-pulse burst.
- **Parameter corner:** PULSE_COUNT=1, HIGH_CYCLES=1, LOW_CYCLES=1 → single 1-cycle pulse, `busy` high 1 cycle, then `done`=1.

Source files
------------

// File: rtl/trigger_burst_gen.sv
// trigger_burst_gen: watches the countdown trigger level. Each rising edge
// launches a burst of PULSE_COUNT pulses, HIGH_CYCLES wide and separated by
// LOW_CYCLES gaps. The block then signals done until trigger falls, which
// re-arms it. Rising edges seen while a burst runs or while done is held
// are dropped, not queued.
module trigger_burst_gen #(
  parameter int PULSE_COUNT = 3,
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  output logic pulse,
  output logic busy,
  output logic done
);

  localparam int MAX_PHASE = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W     = $clog2(MAX_PHASE + 1);
  localparam int NP_W      = $clog2(PULSE_COUNT + 1);

  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST   = CNT_W'(LOW_CYCLES - 1);
  localparam logic [NP_W-1:0]  PULSE_LAST = NP_W'(PULSE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [NP_W-1:0]   npulse, npulse_n;
  logic              trig_q;
  logic              rise;

  assign rise = trigger & ~trig_q;

  // Next-state logic: the phase counter restarts on every state change, and
  // the pulse counter advances when a gap hands over to the next pulse.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    npulse_n = npulse;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n  = HIGH;
          cnt_n    = '0;
          npulse_n = '0;
        end
      end
      HIGH: begin
        if (cnt == HIGH_LAST) begin
          cnt_n   = '0;
          state_n = (npulse == PULSE_LAST) ? DONE : LOW;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt == LOW_LAST) begin
          cnt_n    = '0;
          state_n  = HIGH;
          npulse_n = npulse + NP_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (!trigger) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = '0;
        npulse_n = '0;
      end
    endcase
  end

  // State, counters, edge-detect history and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      npulse <= '0;
      trig_q <= 1'b0;
      pulse  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      npulse <= npulse_n;
      trig_q <= trigger;
      pulse  <= (state_n == HIGH);
      busy   <= (state_n == HIGH) || (state_n == LOW);
      done   <= (state_n == DONE);
    end
  end

endmodule
